// File: rtl/cu_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, FSM states,
// instruction field positions and opcode classification helpers.
package cu_pkg;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_NE  = 6'b100001;
  localparam logic [5:0] OP_LE  = 6'b100010;
  localparam logic [5:0] OP_GT  = 6'b100011;
  localparam logic [5:0] OP_SHL = 6'b110000;
  localparam logic [5:0] OP_SHR = 6'b110001;
  localparam logic [5:0] OP_SRA = 6'b110010;

  localparam int OP_LSB      = 26;
  localparam int RD_LSB      = 23;
  localparam int RS1_LSB     = 20;
  localparam int RS2_LSB     = 17;
  localparam int USE_IMM_BIT = 16;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 16;
  localparam int REG_AW      = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_e;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT,
      OP_SHL, OP_SHR, OP_SRA: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Only the arithmetic ops own the carry/borrow flag.
  function automatic logic writes_carry(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cu_regfile.sv
// Register file with two combinational operand reads, a debug read and one
// synchronous write; entry 0 is hard-wired to zero.
module cu_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra1_i,
  input  logic [AW-1:0]     ra2_i,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  output logic [DATA_W-1:0] dbg_data_o,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o      = (ra1_i == '0)      ? '0 : mem_q[ra1_i];
  assign rd2_o      = (ra2_i == '0)      ? '0 : mem_q[ra2_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/cu_sequencer.sv
// Four-state control unit feeding a combinational ALU: accepts an instruction,
// reads operands, drives the ALU for one cycle, then writes back result and flags.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_carry,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_n,
  output logic              done,
  output logic              illegal,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e              state_q;
  logic [31:0]         instr_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q, res_q;
  logic [OP_W-1:0]     alu_op_q;
  logic                c_q, z_q, n_q, ill_q;
  logic                flag_c_q, flag_z_q, flag_n_q;
  logic                ready_q, done_q, illegal_q;

  logic [5:0]          op;
  logic [REG_AW-1:0]   rd, rs1, rs2;
  logic                use_imm;
  logic [DATA_W-1:0]   imm_ext, rs1_data, rs2_data;
  logic                rf_we;

  assign op      = instr_q[OP_LSB +: 6];
  assign rd      = instr_q[RD_LSB +: REG_AW];
  assign rs1     = instr_q[RS1_LSB +: REG_AW];
  assign rs2     = instr_q[RS2_LSB +: REG_AW];
  assign use_imm = instr_q[USE_IMM_BIT];
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, instr_q[IMM_LSB +: IMM_W]};
  assign rf_we   = (state_q == S_WB) && !ill_q;

  cu_regfile #(
    .DATA_W(DATA_W),
    .NREG  (NREG),
    .AW    (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .ra1_i     (rs1),
    .ra2_i     (rs2),
    .dbg_addr_i(dbg_addr),
    .rd1_o     (rs1_data),
    .rd2_o     (rs2_data),
    .dbg_data_o(dbg_data),
    .we_i      (rf_we),
    .wa_i      (rd),
    .wd_i      (res_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      res_q     <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      ill_q     <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid && ready_q) begin
            instr_q <= instr;
            ready_q <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          alu_a_q <= rs1_data;
          alu_b_q <= use_imm ? imm_ext : rs2_data;
          if (is_legal(op)) begin
            alu_op_q <= OP_W'(op);
            ill_q    <= 1'b0;
            state_q  <= S_EXEC;
          end else begin
            // Illegal ops skip the ALU and retire straight from WB.
            ill_q     <= 1'b1;
            done_q    <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= S_WB;
          end
        end
        S_EXEC: begin
          res_q    <= alu_res;
          c_q      <= alu_carry;
          z_q      <= alu_z;
          n_q      <= alu_n;
          alu_op_q <= OP_W'(OP_NOP);
          done_q   <= 1'b1;
          state_q  <= S_WB;
        end
        S_WB: begin
          if (!ill_q) begin
            flag_z_q <= z_q;
            flag_n_q <= n_q;
            if (writes_carry(op)) flag_c_q <= c_q;
          end
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer with a behavioural ALU and a scoreboard of
// predicted retirements.
`timescale 1ns/100ps
module tb_cu_sequencer;

  localparam logic [5:0] ADD = 6'b010000, SUB = 6'b010001;
  localparam logic [5:0] EQ  = 6'b100000, NE  = 6'b100001;
  localparam logic [5:0] LE  = 6'b100010, GT  = 6'b100011;
  localparam logic [5:0] SHL = 6'b110000, SHR = 6'b110001, SRA = 6'b110010;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [5:0]  alu_op;
  logic        alu_carry, alu_z, alu_n;
  logic        flag_c, flag_z, flag_n, done, illegal;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] res;
    logic        c, z, n, ill, upd_c;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mreg [8];
  logic        mc, mz, mn;
  int          n_chk = 0, n_pass = 0, n_fail = 0;

  cu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_z(alu_z), .alu_n(alu_n),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .done(done),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU, carry-in 0; SUB reports borrow in the carry bit.
  function automatic logic [32:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ADD:     return {1'b0, a} + {1'b0, b};
      SUB:     return {(a < b), a - b};
      EQ:      return {32'b0, (a == b)};
      NE:      return {32'b0, (a != b)};
      LE:      return {32'b0, ($signed(a) <= $signed(b))};
      GT:      return {32'b0, ($signed(a) > $signed(b))};
      SHL:     return {1'b0, a << b[4:0]};
      SHR:     return {1'b0, a >> b[4:0]};
      SRA:     return {1'b0, $unsigned($signed(a) >>> b[4:0])};
      default: return 33'b0;
    endcase
  endfunction

  logic [32:0] alu_full;
  always_comb alu_full = alu_f(alu_op, alu_a, alu_b);
  assign alu_res   = alu_full[31:0];
  assign alu_carry = alu_full[32];
  assign alu_z     = (alu_full[31:0] == 32'b0);
  assign alu_n     = alu_full[31];

  function automatic logic [31:0] mk(input logic [5:0] op, input int rd, input int rs1,
                                     input int rs2, input logic ui, input logic [15:0] imm);
    return {op, 3'(rd), 3'(rs1), 3'(rs2), ui, imm};
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {ADD, SUB, EQ, NE, LE, GT, SHL, SHR, SRA};
  endfunction

  function automatic exp_t predict(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] a, b;
    logic [32:0] r;
    a       = mreg[ins[22:20]];
    b       = ins[16] ? {16'h0, ins[15:0]} : mreg[ins[19:17]];
    r       = alu_f(ins[31:26], a, b);
    e.rd    = ins[25:23];
    e.res   = r[31:0];
    e.c     = r[32];
    e.z     = (r[31:0] == 32'b0);
    e.n     = r[31];
    e.ill   = !legal_op(ins[31:26]);
    e.upd_c = (ins[31:26] == ADD) || (ins[31:26] == SUB);
    return e;
  endfunction

  task automatic retire(input exp_t e);
    if (!e.ill) begin
      if (e.rd != 3'd0) mreg[e.rd] = e.res;
      mz = e.z;
      mn = e.n;
      if (e.upd_c) mc = e.c;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 32'b0;
    mc = 1'b0; mz = 1'b0; mn = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_flag_c"}, flag_c, mc);
    chk({tag, "_flag_z"}, flag_z, mz);
    chk({tag, "_flag_n"}, flag_n, mn);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), dbg_data, mreg[i]);
    end
  endtask

  task automatic peek(input string tag, input int r, input logic [31:0] exp);
    dbg_addr = 3'(r);
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // One instruction end to end; returns at the negedge of the cycle after done.
  task automatic run_instr(input logic [31:0] ins);
    exp_t e;
    int   cyc;
    sb.push_back(predict(ins));
    @(negedge clk);
    chk("ready_idle", instr_ready, 1);
    instr       = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    cyc = 1;
    chk("ready_busy", instr_ready, 0);
    while (!done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    chk("done_seen", done, 1);
    chk("latency", cyc, e.ill ? 2 : 3);
    chk("illegal_qual", illegal, e.ill);
    retire(e);
    dbg_addr = e.rd;
    @(negedge clk);
    chk("ready_back", instr_ready, 1);
    chk("done_one_cycle", done, 0);
    chk("alu_op_between", alu_op, 0);
    chk("wb_visible", dbg_data, mreg[e.rd]);
    chk("flag_c", flag_c, mc);
    chk("flag_z", flag_z, mz);
    chk("flag_n", flag_n, mn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog [3];
    int          acc, dn, idx, ndone;
    int          acc_cyc [3];
    logic        took;
    exp_t        e;

    rst = 1'b1; instr_valid = 1'b0; instr = 32'b0; dbg_addr = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    rst = 1'b0;
    check_all("rst");

    // Basic immediate add
    run_instr(mk(ADD, 1, 0, 0, 1, 16'h0005));
    peek("add_imm_r1", 1, 32'h0000_0005);

    // Build 0xFFFFFFFF, then wrap it to zero
    run_instr(mk(ADD, 1, 0, 0, 1, 16'hFFFF));
    run_instr(mk(SHL, 2, 1, 0, 1, 16'd16));
    peek("shl_r2", 2, 32'hFFFF_0000);
    run_instr(mk(ADD, 3, 2, 1, 0, 16'h0));
    peek("add_r3", 3, 32'hFFFF_FFFF);
    chk("add_r3_n", flag_n, 1);
    run_instr(mk(ADD, 4, 3, 0, 1, 16'h0001));
    peek("wrap_r4", 4, 32'h0);
    chk("wrap_c", flag_c, 1);
    chk("wrap_z", flag_z, 1);

    // Shifts on a negative value
    run_instr(mk(SRA, 5, 2, 0, 1, 16'd4));
    peek("sra_r5", 5, 32'hFFFF_F000);
    run_instr(mk(SHR, 6, 2, 0, 1, 16'd4));
    peek("shr_r6", 6, 32'h0FFF_F000);

    // Compares; carry set by a borrowing SUB to r0 must survive them
    run_instr(mk(ADD, 1, 0, 0, 1, 16'd5));
    run_instr(mk(ADD, 2, 0, 0, 1, 16'd5));
    run_instr(mk(SUB, 0, 0, 1, 0, 16'd0));
    peek("r0_dropped", 0, 32'h0);
    chk("borrow_c", flag_c, 1);
    run_instr(mk(EQ, 5, 1, 2, 0, 16'd0));
    peek("eq_r5", 5, 32'd1);
    run_instr(mk(GT, 6, 1, 2, 0, 16'd0));
    peek("gt_r6", 6, 32'd0);
    chk("gt_z", flag_z, 1);
    chk("gt_c_kept", flag_c, 1);
    run_instr(mk(LE, 7, 3, 1, 0, 16'd0));
    peek("le_r7", 7, 32'd1);
    run_instr(mk(NE, 7, 1, 2, 0, 16'd0));
    peek("ne_r7", 7, 32'd0);

    // Illegal opcode
    run_instr(mk(6'b111111, 1, 2, 3, 1, 16'h1234));
    check_all("after_illegal");

    // instr_valid held high across three queued instructions
    prog[0] = mk(ADD, 1, 0, 0, 1, 16'd1);
    prog[1] = mk(ADD, 2, 1, 0, 1, 16'd2);
    prog[2] = mk(SUB, 3, 2, 1, 0, 16'd0);
    acc = 0; dn = 0; idx = 0;
    @(negedge clk);
    instr = prog[0];
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      took = 1'b0;
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("b2b_illegal", illegal, 0);
          retire(e);
        end
        dn++;
      end
      if (instr_valid && instr_ready) begin
        sb.push_back(predict(instr));
        if (acc < 3) acc_cyc[acc] = cyc;
        acc++;
        took = 1'b1;
      end
      @(negedge clk);
      if (took) begin
        idx++;
        if (idx < 3) instr = prog[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", acc, 3);
    chk("b2b_dones", dn, 3);
    chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 4);
    chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 4);
    peek("b2b_r3", 3, 32'd2);
    check_all("b2b");

    // Reset during EXEC with nonzero flags beforehand
    run_instr(mk(SUB, 5, 0, 1, 0, 16'd0));
    chk("pre_rst_n", flag_n, 1);
    chk("pre_rst_c", flag_c, 1);
    @(negedge clk);
    instr = mk(ADD, 7, 0, 0, 1, 16'd9);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_alu_op", alu_op, ADD);
    chk("exec_alu_b", alu_b, 32'd9);
    rst = 1'b1;
    #1;
    chk("async_flag_n", flag_n, 0);
    chk("async_ready", instr_ready, 1);
    sb.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    chk("post_rst_ready", instr_ready, 1);
    peek("post_rst_r7", 7, 32'h0);
    check_all("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
